// File: rtl/ram8_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto a single-port 8x4 RAM.
// Writes take one cycle after grant; read data returns with a one-cycle valid strobe.
module ram8_arbiter #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state;
    logic   ptr_b;      // 1: B wins the next tie
    logic   owner_b;    // requester that owns the command in flight

    logic              any_req_c;
    logic              pick_b_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Winner selection: sole requester, or the pointer on a tie
    always_comb begin
        any_req_c   = req_a | req_b;
        pick_b_c    = req_b & (~req_a | ptr_b);
        sel_we_c    = pick_b_c ? we_b    : we_a;
        sel_addr_c  = pick_b_c ? addr_b  : addr_a;
        sel_wdata_c = pick_b_c ? wdata_b : wdata_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr_b    <= 1'b0;
            owner_b  <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            ram_load <= 1'b0;
            ram_add  <= '0;
            ram_in   <= '0;
            busy     <= 1'b0;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        ram_add  <= sel_addr_c;
                        ram_in   <= sel_wdata_c;
                        ram_load <= sel_we_c;
                        gnt_a    <= ~pick_b_c;
                        gnt_b    <= pick_b_c;
                        busy     <= 1'b1;
                        ptr_b    <= ~pick_b_c;
                        owner_b  <= pick_b_c;
                        state    <= sel_we_c ? WRITE : READ;
                    end
                end
                WRITE: begin
                    ram_load <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                READ: begin
                    // ram_add has been stable for a full cycle, so ram_out is valid here
                    if (owner_b) begin
                        rdata_b  <= ram_out;
                        rvalid_b <= 1'b1;
                    end else begin
                        rdata_a  <= ram_out;
                        rvalid_a <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ram_load <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural 8x4 RAM (sync write, async read).
module tb_ram8_arbiter;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              ram_load, busy;
    logic [ADDR_W-1:0] ram_add;
    logic [DATA_W-1:0] ram_in, ram_out;

    logic [DATA_W-1:0] mem [8];

    int compared   = 0;
    int mismatched = 0;

    ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_load(ram_load), .ram_add(ram_add), .ram_in(ram_in),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_load) mem[ram_add] <= ram_in;
    assign ram_out = mem[ram_add];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

        // 1: reset state
        tick(); tick();
        check("rst_ctl", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_load, busy}), 32'd0);
        check("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
        check("rst_ram", 32'({ram_add, ram_in}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_load_busy", 32'({ram_load, busy}), 32'd0);
        end

        // 2: A writes 1100 @2, then reads it back
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'b010; wdata_a = 4'b1100;
        tick();
        check("wr_gnt", 32'({gnt_a, gnt_b, ram_load, busy}), 32'b1011);
        check("wr_bus", 32'({ram_add, ram_in}), 32'({3'b010, 4'b1100}));
        req_a = 1'b0;
        tick();
        check("wr_done", 32'({gnt_a, ram_load, busy}), 32'd0);
        check("wr_mem", 32'(mem[2]), 32'hC);
        req_a = 1'b1; we_a = 1'b0;
        tick();
        check("rd_gnt", 32'({gnt_a, ram_load, busy, rvalid_a}), 32'b1010);
        req_a = 1'b0;
        tick();
        check("rd_valid", 32'({rvalid_a, gnt_a, busy}), 32'b100);
        check("rd_data", 32'(rdata_a), 32'hC);
        tick();
        check("rd_hold", 32'({rvalid_a, rdata_a}), 32'h0C);

        // 3: both hold write requests from reset, alternating A,B
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd0; wdata_a = 4'b0011;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; wdata_b = 4'b0101;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_order", 32'({gnt_a, gnt_b}),
                  (k % 4 == 0) ? 32'b10 : (k % 4 == 2) ? 32'b01 : 32'b00);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        check("rr_mem0", 32'(mem[0]), 32'h3);
        check("rr_mem1", 32'(mem[1]), 32'h5);

        // 4a: tie A write 1111 @7 / B read @7, pointer at A
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd7; wdata_a = 4'b1111;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd7;
        tick();
        check("tie1_gnt", 32'({gnt_a, gnt_b}), 32'b10);
        req_a = 1'b0;
        tick();
        tick();
        check("tie1_gnt_b", 32'({gnt_a, gnt_b}), 32'b01);
        req_b = 1'b0;
        tick();
        check("tie1_rvalid", 32'({rvalid_b, rdata_b}), 32'h1F);

        // move pointer to B with a lone A read of @0
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
        tick();
        req_a = 1'b0;
        tick();
        check("solo_rd", 32'({rvalid_a, rdata_a}), 32'h13);

        // 4b: tie A write 1010 @7 / B read @7, pointer at B
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd7; wdata_a = 4'b1010;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd7;
        tick();
        check("tie2_gnt", 32'({gnt_a, gnt_b}), 32'b01);
        req_b = 1'b0;
        tick();
        check("tie2_old", 32'({rvalid_b, rdata_b}), 32'h1F);
        tick();
        check("tie2_gnt_a", 32'({gnt_a, gnt_b, ram_load}), 32'b101);
        req_a = 1'b0;
        tick();
        check("tie2_mem", 32'(mem[7]), 32'hA);

        // 5a: reset during READ
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd7;
        tick();
        check("rstrd_acc", 32'({gnt_a, busy}), 32'b11);
        req_a = 1'b0; reset = 1'b1;
        tick();
        check("rstrd_out", 32'({rvalid_a, rdata_a, busy, gnt_a}), 32'd0);
        reset = 1'b0;
        tick();
        check("rstrd_idle", 32'({rvalid_a, busy, ram_load}), 32'd0);

        // 5b: reset during WRITE, B writes 0110 @5
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd5; wdata_b = 4'b0110;
        tick();
        check("rstwr_acc", 32'({gnt_b, ram_load}), 32'b11);
        req_b = 1'b0; reset = 1'b1;
        tick();
        check("rstwr_mem", 32'(mem[5]), 32'h6);
        check("rstwr_out", 32'({busy, ram_load, ram_add, ram_in}), 32'd0);
        reset = 1'b0;

        // 6: both hold read requests; B granted within 4 cycles, single-cycle gnt pulses
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd1;
        begin
            int wait_b = 0;
            logic seen_b = 1'b0;
            logic prev_a = 1'b0, prev_b = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (!seen_b) begin
                    wait_b = k;
                    seen_b = gnt_b;
                end
                check("hold_pattern", 32'({gnt_a, gnt_b}),
                      (k % 4 == 1) ? 32'b10 : (k % 4 == 3) ? 32'b01 : 32'b00);
                check("gnt_pulse", 32'({gnt_a & prev_a, gnt_b & prev_b}), 32'd0);
                prev_a = gnt_a;
                prev_b = gnt_b;
            end
            check("starve_seen", 32'(seen_b), 32'd1);
            check("starve_bound", 32'(wait_b <= 4), 32'd1);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
